timer_alarm_sequencer: RTL and testbench
========================================

Name: timer_alarm_sequencer

Overview:
- Avalon-MM master that configures and services the system interval timer (16-bit register slave, irq output) to keep time-of-day for the alarm clock.
- After reset it programs the timer period and starts it in continuous mode with interrupts enabled.
- On each timer irq it clears the timeout status, advances a sub-second tick count, and rolls hh:mm:ss.
- It compares the time against a programmable alarm and latches an alarm flag until acknowledged.

Parameters:
- PERIOD, 32'd49999: timer reload value written to period_l/period_h (1 ms at 50 MHz).
- TICKS_PER_SEC, 1000: timer irqs per second; range 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tmr_address  out  3  timer register address (0 status, 1 control, 2 period_l, 3 period_h)
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  active-low write strobe
- tmr_writedata  out  16  timer write data
- tmr_irq  in  1  timer interrupt (level; low the cycle after a status write)
- set_time  in  1  one-cycle pulse: load set_hh/set_mm/set_ss
- set_hh  in  5  hours 0..23
- set_mm  in  6  minutes 0..59
- set_ss  in  6  seconds 0..59
- alarm_hh  in  5  alarm hour
- alarm_mm  in  6  alarm minute
- alarm_en  in  1  alarm enable (level)
- alarm_ack  in  1  one-cycle pulse: clear alarm_active
- hh  out  5  current hour
- mm  out  6  current minute
- ss  out  6  current second
- tick_1hz  out  1  one-cycle pulse on each seconds increment
- alarm_active  out  1  latched alarm
- running  out  1  high in RUN and ACK

Behaviour:
- Reset:
  - All outputs 0; tmr_write_n=1; tmr_chipselect=0; tmr_address=0; tmr_writedata=0.
  - subsec=0; state=INIT_PL.
  - Reset mid-sequence abandons any write and restarts at INIT_PL.
- Bus protocol:
  - A write occupies exactly one cycle: chipselect=1, write_n=0, with address and data driven for that cycle.
  - There is no waitrequest and there are no reads.
  - Outside write states: chipselect=0, write_n=1.
- FSM, one write per state, each lasting one cycle unless noted:
  - INIT_PL: addr 2, data PERIOD[15:0] -> INIT_PH.
  - INIT_PH: addr 3, data PERIOD[31:16] -> CLR.
  - CLR: addr 0, data 0, clears any stale timeout -> CTRL.
  - CTRL: addr 1, data 16'h0007 (START|CONT|ITO) -> RUN.
  - RUN: no bus activity; waits in this state.
    - set_time -> RS_PL, loading the time registers and clearing subsec this cycle.
    - else tmr_irq -> ACK.
  - ACK: addr 0, data 0; performs the tick update (below) -> RUN.
  - RS_PL: addr 2, data PERIOD[15:0]. This forces a timer reload and stops the timer, giving phase-aligned seconds -> CLR.
- Priority and simultaneous events:
  - set_time outside RUN is ignored.
  - set_time together with tmr_irq in RUN: set_time wins. The pending tick is discarded and its status is cleared via CLR.
- Tick update in ACK:
  - If subsec == TICKS_PER_SEC-1: subsec=0, pulse tick_1hz, and increment ss.
    - ss 59->0 carries into mm; mm 59->0 carries into hh; hh 23->0.
  - Else subsec+1.
- Alarm:
  - Evaluated in the same ACK cycle on the new time.
  - Match condition: alarm_en & new hh==alarm_hh & new mm==alarm_mm & new ss==0. Match sets alarm_active.
  - alarm_ack clears alarm_active.
  - Match and ack in the same cycle: set wins.
  - Loading via set_time never triggers an alarm.
  - Deasserting alarm_en does not clear alarm_active.
- Out-of-range inputs: set values out of range (hh>23, mm/ss>59) are clamped to the maximum legal value.
- Latencies:
  - Reset deasserted -> first timer write: 0 cycles (INIT_PL is the first cycle).
  - Timer running after 4 writes.
  - irq -> status write: 1 cycle.
  - irq -> updated time outputs: 2 cycles.

Test Plan:
1. Reset, PERIOD=9, TICKS_PER_SEC=4 -> four consecutive writes (2:0x0009, 3:0x0000, 0:0x0000, 1:0x0007), then running=1 with no bus activity.
2. Drive 4 irqs, each dropped 1 cycle after its addr-0 write -> ss goes 0->1; tick_1hz pulses exactly once, during the 4th ACK.
3. set_time 23:59:59, then 4 irqs -> hh:mm:ss=00:00:00; a preceding RS_PL/CLR/CTRL write sequence is observed.
4. alarm 07:30, en=1, set 07:29:59, then 4 irqs -> alarm_active=1 in the cycle after ACK; alarm_ack clears it; an ack coincident with a match leaves it set.
5. set_time and tmr_irq asserted in the same RUN cycle -> time equals the set value (no increment) and subsec=0; the bus shows addr2, addr0, addr1 writes.
6. Reset asserted during CTRL -> outputs return to reset values; the next cycle performs the INIT_PL write again.

Source files
------------

// File: rtl/timer_alarm_sequencer.sv
// ---------------------------------------------------------------------------
// timer_alarm_sequencer
//
// Avalon-MM write-only master that programs and services an interval timer
// to keep time of day for an alarm clock.
//
// After reset the block writes the timer period and then the control word
// (START|CONT|ITO). After that it waits in RUN. Each timer interrupt is
// acknowledged by a status write. TICKS_PER_SEC interrupts make one second,
// and each second rolls hh:mm:ss forward.
// A programmable hh:mm alarm is matched at second zero. The match sets a
// flag that stays set until it is acknowledged.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   tmr_address         timer register (0 status, 1 control, 2 period_l,
//                       3 period_h)
//   tmr_chipselect      timer select, high only during a write cycle
//   tmr_write_n         active-low write strobe
//   tmr_writedata       16-bit timer write data
//   tmr_irq             timer interrupt (level)
//   set_time            one-cycle pulse, loads set_hh/set_mm/set_ss (RUN only)
//   set_hh/mm/ss        time to load, clamped to 23/59/59
//   alarm_hh/mm         alarm time
//   alarm_en            alarm enable (level)
//   alarm_ack           one-cycle pulse, clears alarm_active
//   hh, mm, ss          current time of day
//   tick_1hz            one-cycle pulse during the ACK that advances seconds
//   alarm_active        latched alarm flag
//   running             high while the timer is serviced (RUN and ACK)
// ---------------------------------------------------------------------------
module timer_alarm_sequencer #(
  parameter logic [31:0] PERIOD        = 32'd49999,
  parameter int unsigned TICKS_PER_SEC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic        tmr_irq,
  input  logic        set_time,
  input  logic [4:0]  set_hh,
  input  logic [5:0]  set_mm,
  input  logic [5:0]  set_ss,
  input  logic [4:0]  alarm_hh,
  input  logic [5:0]  alarm_mm,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic [4:0]  hh,
  output logic [5:0]  mm,
  output logic [5:0]  ss,
  output logic        tick_1hz,
  output logic        alarm_active,
  output logic        running
);

  // FSM encoding: every state except RUN issues exactly one bus write
  localparam logic [2:0] S_INIT_PL = 3'd0;
  localparam logic [2:0] S_INIT_PH = 3'd1;
  localparam logic [2:0] S_CLR     = 3'd2;
  localparam logic [2:0] S_CTRL    = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_ACK     = 3'd5;
  localparam logic [2:0] S_RS_PL   = 3'd6;

  localparam logic [2:0]  A_STATUS   = 3'd0;
  localparam logic [2:0]  A_CONTROL  = 3'd1;
  localparam logic [2:0]  A_PERIOD_L = 3'd2;
  localparam logic [2:0]  A_PERIOD_H = 3'd3;
  localparam logic [15:0] CTRL_WORD  = 16'h0007;  // START | CONT | ITO
  localparam logic [15:0] SUBSEC_MAX = 16'(TICKS_PER_SEC - 32'd1);

  // Saturate user-supplied time fields to their largest legal value
  function automatic logic [4:0] clamp_hour(input logic [4:0] v);
    return (v > 5'd23) ? 5'd23 : v;
  endfunction

  function automatic logic [5:0] clamp_sixty(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [15:0] subsec_q, subsec_d;
  logic [4:0]  hh_q, hh_d;
  logic [5:0]  mm_q, mm_d;
  logic [5:0]  ss_q, ss_d;
  logic        tick_1hz_q, tick_1hz_d;
  logic        alarm_q, alarm_d;
  logic        running_q, running_d;
  logic        alarm_match;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  // Next-state logic for the timer programming / servicing sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT_PL: state_d = S_INIT_PH;
      S_INIT_PH: state_d = S_CLR;
      S_CLR:     state_d = S_CTRL;
      S_CTRL:    state_d = S_RUN;
      S_RUN: begin
        // set_time beats a pending irq; CLR later clears its status
        if (set_time) begin
          state_d = S_RS_PL;
        end else if (tmr_irq) begin
          state_d = S_ACK;
        end else begin
          state_d = S_RUN;
        end
      end
      S_ACK:     state_d = S_RUN;
      S_RS_PL:   state_d = S_CLR;
      default:   state_d = S_INIT_PL;
    endcase
  end

  // Bus write decode, one write per non-RUN state; held idle while in reset
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = A_STATUS;
    wr_data = 16'h0000;
    if (reset) begin
      wr_en = 1'b0;
    end else begin
      case (state_q)
        S_INIT_PL, S_RS_PL: begin
          // Writing period_l reloads and stops the timer, so the next
          // second starts from the moment of the write
          wr_en   = 1'b1;
          wr_addr = A_PERIOD_L;
          wr_data = PERIOD[15:0];
        end
        S_INIT_PH: begin
          wr_en   = 1'b1;
          wr_addr = A_PERIOD_H;
          wr_data = PERIOD[31:16];
        end
        S_CLR, S_ACK: begin
          wr_en   = 1'b1;
          wr_addr = A_STATUS;
          wr_data = 16'h0000;
        end
        S_CTRL: begin
          wr_en   = 1'b1;
          wr_addr = A_CONTROL;
          wr_data = CTRL_WORD;
        end
        default: begin
          wr_en   = 1'b0;
          wr_addr = A_STATUS;
          wr_data = 16'h0000;
        end
      endcase
    end
  end

  // Time-of-day, sub-second counter and alarm flag update
  always_comb begin
    hh_d        = hh_q;
    mm_d        = mm_q;
    ss_d        = ss_q;
    subsec_d    = subsec_q;
    alarm_d     = alarm_q;
    alarm_match = 1'b0;

    // A plain acknowledge clears the flag; a match in the same cycle wins
    if (alarm_ack) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end

    if ((state_q == S_RUN) && set_time) begin
      // Loading never evaluates the alarm
      hh_d     = clamp_hour(set_hh);
      mm_d     = clamp_sixty(set_mm);
      ss_d     = clamp_sixty(set_ss);
      subsec_d = 16'd0;
    end else if (state_q == S_ACK) begin
      if (subsec_q == SUBSEC_MAX) begin
        subsec_d = 16'd0;
        if (ss_q >= 6'd59) begin
          ss_d = 6'd0;
          if (mm_q >= 6'd59) begin
            mm_d = 6'd0;
            hh_d = (hh_q >= 5'd23) ? 5'd0 : hh_q + 5'd1;
          end else begin
            mm_d = mm_q + 6'd1;
          end
        end else begin
          ss_d = ss_q + 6'd1;
        end
      end else begin
        subsec_d = subsec_q + 16'd1;
      end
      // Compare against the time this ACK produces, not the old time
      alarm_match = alarm_en && (hh_d == alarm_hh) && (mm_d == alarm_mm) &&
                    (ss_d == 6'd0);
      if (alarm_match) begin
        alarm_d = 1'b1;
      end else begin
        alarm_d = alarm_d;
      end
    end else begin
      subsec_d = subsec_q;
    end
  end

  // Output strobes derived from the upcoming state so their flops line up
  // with the state they describe
  always_comb begin
    running_d  = (state_d == S_RUN) || (state_d == S_ACK);
    tick_1hz_d = (state_d == S_ACK) && (subsec_q == SUBSEC_MAX);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT_PL;
      subsec_q   <= 16'd0;
      hh_q       <= 5'd0;
      mm_q       <= 6'd0;
      ss_q       <= 6'd0;
      tick_1hz_q <= 1'b0;
      alarm_q    <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      subsec_q   <= subsec_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      tick_1hz_q <= tick_1hz_d;
      alarm_q    <= alarm_d;
      running_q  <= running_d;
    end
  end

  assign tmr_chipselect = wr_en;
  assign tmr_write_n    = ~wr_en;
  assign tmr_address    = wr_addr;
  assign tmr_writedata  = wr_data;
  assign hh             = hh_q;
  assign mm             = mm_q;
  assign ss             = ss_q;
  assign tick_1hz       = tick_1hz_q;
  assign alarm_active   = alarm_q;
  assign running        = running_q;

endmodule

// File: tb/tb_timer_alarm_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for timer_alarm_sequencer (PERIOD=9, TICKS_PER_SEC=4).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// following falling edge, so each sample shows the cycle those inputs drive.
// ---------------------------------------------------------------------------
module tb_timer_alarm_sequencer;

  logic        clk;
  logic        reset;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;
  logic        set_time;
  logic [4:0]  set_hh;
  logic [5:0]  set_mm;
  logic [5:0]  set_ss;
  logic [4:0]  alarm_hh;
  logic [5:0]  alarm_mm;
  logic        alarm_en;
  logic        alarm_ack;
  logic [4:0]  hh;
  logic [5:0]  mm;
  logic [5:0]  ss;
  logic        tick_1hz;
  logic        alarm_active;
  logic        running;

  int vectors     = 0;
  int miscompares = 0;

  // {chipselect, write_n, address, writedata}
  logic [20:0] bus;
  assign bus = {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};

  localparam logic [20:0] W_PL = {1'b1, 1'b0, 3'd2, 16'h0009};
  localparam logic [20:0] W_PH = {1'b1, 1'b0, 3'd3, 16'h0000};
  localparam logic [20:0] W_ST = {1'b1, 1'b0, 3'd0, 16'h0000};
  localparam logic [20:0] W_CT = {1'b1, 1'b0, 3'd1, 16'h0007};

  timer_alarm_sequencer #(.PERIOD(32'd9), .TICKS_PER_SEC(4)) dut (
    .clk(clk), .reset(reset),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_irq(tmr_irq), .set_time(set_time),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_en(alarm_en),
    .alarm_ack(alarm_ack), .hh(hh), .mm(mm), .ss(ss),
    .tick_1hz(tick_1hz), .alarm_active(alarm_active), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One timer interrupt: RUN cycle with irq, ACK cycle (sampled), then the
  // RUN cycle after ACK where irq is low again and the new time is visible.
  task automatic pulse_irq(input logic ack_during, output logic tick_seen,
                           output logic [20:0] ack_bus);
    @(posedge clk); #1; tmr_irq = 1'b1;
    @(posedge clk); #1; alarm_ack = ack_during;
    @(negedge clk); tick_seen = tick_1hz; ack_bus = bus;
    @(posedge clk); #1; tmr_irq = 1'b0; alarm_ack = 1'b0;
    @(negedge clk);
  endtask

  // set_time pulse from RUN, optionally with a coincident irq; captures the
  // three following bus cycles and returns in the CTRL cycle.
  task automatic do_set(input logic [4:0] h, input logic [5:0] m,
                        input logic [5:0] s, input logic with_irq,
                        output logic [20:0] s0, output logic [20:0] s1,
                        output logic [20:0] s2);
    @(posedge clk); #1;
    set_time = 1'b1; set_hh = h; set_mm = m; set_ss = s; tmr_irq = with_irq;
    @(posedge clk); #1; set_time = 1'b0;
    @(negedge clk); s0 = bus;
    @(posedge clk); #1;
    @(negedge clk); s1 = bus;
    @(posedge clk); #1; tmr_irq = 1'b0;
    @(negedge clk); s2 = bus;
  endtask

  task automatic test_reset;
    logic [20:0] seq [4];
    seq = '{W_PL, W_PH, W_ST, W_CT};
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    vectors++;
    if ({bus, hh, mm, ss, tick_1hz, alarm_active, running} !==
        {1'b0, 1'b1, 3'd0, 16'h0000, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0})
      begin
      miscompares++;
      $display("FAIL reset_state: got bus=%h t=%0d:%0d:%0d tk=%b al=%b run=%b",
               bus, hh, mm, ss, tick_1hz, alarm_active, running);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus !== seq[i]) begin
        miscompares++;
        $display("FAIL init_write%0d: got %h expected %h", i, bus, seq[i]);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({tmr_chipselect, tmr_write_n, running} !== 3'b011) begin
      miscompares++;
      $display("FAIL run_idle: got cs=%b wn=%b run=%b expected 0 1 1",
               tmr_chipselect, tmr_write_n, running);
    end
  endtask

  task automatic test_tick;
    logic t;
    logic [20:0] b;
    logic [5:0] exp_ss;
    for (int i = 0; i < 4; i++) begin
      pulse_irq(1'b0, t, b);
      exp_ss = (i == 3) ? 6'd1 : 6'd0;
      vectors++;
      if (b !== W_ST) begin
        miscompares++;
        $display("FAIL tick_ack_write%0d: got %h expected %h", i, b, W_ST);
      end
      vectors++;
      if (t !== (i == 3)) begin
        miscompares++;
        $display("FAIL tick_1hz%0d: got %b expected %b", i, t, (i == 3));
      end
      vectors++;
      if ({hh, mm, ss} !== {5'd0, 6'd0, exp_ss}) begin
        miscompares++;
        $display("FAIL tick_time%0d: got %0d:%0d:%0d expected 0:0:%0d",
                 i, hh, mm, ss, exp_ss);
      end
    end
    vectors++;
    if (tick_1hz !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_width: got %b expected 0", tick_1hz);
    end
  endtask

  task automatic test_rollover;
    logic t;
    logic [20:0] b, s0, s1, s2;
    do_set(5'd23, 6'd59, 6'd59, 1'b0, s0, s1, s2);
    vectors++;
    if ({s0, s1, s2} !== {W_PL, W_ST, W_CT}) begin
      miscompares++;
      $display("FAIL set_bus_seq: got %h %h %h expected %h %h %h",
               s0, s1, s2, W_PL, W_ST, W_CT);
    end
    vectors++;
    if ({hh, mm, ss} !== {5'd23, 6'd59, 6'd59}) begin
      miscompares++;
      $display("FAIL set_load: got %0d:%0d:%0d expected 23:59:59", hh, mm, ss);
    end
    for (int i = 0; i < 4; i++) pulse_irq(1'b0, t, b);
    vectors++;
    if ({hh, mm, ss, t} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL rollover: got %0d:%0d:%0d tick=%b expected 0:0:0 tick=1",
               hh, mm, ss, t);
    end
  endtask

  task automatic test_alarm;
    logic t;
    logic [20:0] b, s0, s1, s2;
    @(posedge clk); #1;
    alarm_hh = 5'd7; alarm_mm = 6'd30; alarm_en = 1'b1;
    do_set(5'd7, 6'd29, 6'd59, 1'b0, s0, s1, s2);
    for (int i = 0; i < 4; i++) begin
      pulse_irq(1'b0, t, b);
      vectors++;
      if (alarm_active !== (i == 3)) begin
        miscompares++;
        $display("FAIL alarm_irq%0d: got %b expected %b (time %0d:%0d:%0d)",
                 i, alarm_active, (i == 3), hh, mm, ss);
      end
    end
    vectors++;
    if ({hh, mm, ss} !== {5'd7, 6'd30, 6'd0}) begin
      miscompares++;
      $display("FAIL alarm_time: got %0d:%0d:%0d expected 7:30:0", hh, mm, ss);
    end
    // ack in the same ACK cycle as a fresh match: set wins
    pulse_irq(1'b1, t, b);
    vectors++;
    if (alarm_active !== 1'b1) begin
      miscompares++;
      $display("FAIL alarm_set_wins: got %b expected 1", alarm_active);
    end
    @(posedge clk); #1; alarm_ack = 1'b1;
    @(posedge clk); #1; alarm_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (alarm_active !== 1'b0) begin
      miscompares++;
      $display("FAIL alarm_ack_clear: got %b expected 0", alarm_active);
    end
    // loading the alarm time itself must not raise the flag
    do_set(5'd7, 6'd30, 6'd0, 1'b0, s0, s1, s2);
    vectors++;
    if (alarm_active !== 1'b0) begin
      miscompares++;
      $display("FAIL alarm_no_set_trigger: got %b expected 0", alarm_active);
    end
    pulse_irq(1'b0, t, b);
    @(posedge clk); #1; alarm_en = 1'b0;
    pulse_irq(1'b0, t, b);
    vectors++;
    if (alarm_active !== 1'b1) begin
      miscompares++;
      $display("FAIL alarm_en_drop_keeps: got %b expected 1", alarm_active);
    end
    @(posedge clk); #1; alarm_ack = 1'b1;
    @(posedge clk); #1; alarm_ack = 1'b0;
  endtask

  task automatic test_set_irq_collision;
    logic t;
    logic [20:0] b, s0, s1, s2;
    // subsec is 2 here (two irqs since the last load)
    do_set(5'd12, 6'd34, 6'd56, 1'b1, s0, s1, s2);
    vectors++;
    if ({s0, s1, s2} !== {W_PL, W_ST, W_CT}) begin
      miscompares++;
      $display("FAIL collide_bus_seq: got %h %h %h expected %h %h %h",
               s0, s1, s2, W_PL, W_ST, W_CT);
    end
    vectors++;
    if ({hh, mm, ss} !== {5'd12, 6'd34, 6'd56}) begin
      miscompares++;
      $display("FAIL collide_time: got %0d:%0d:%0d expected 12:34:56",
               hh, mm, ss);
    end
    for (int i = 0; i < 4; i++) begin
      pulse_irq(1'b0, t, b);
      vectors++;
      if ({ss, t} !== {((i == 3) ? 6'd57 : 6'd56), (i == 3)}) begin
        miscompares++;
        $display("FAIL collide_subsec%0d: got ss=%0d tick=%b", i, ss, t);
      end
    end
  endtask

  task automatic test_clamp;
    logic [20:0] s0, s1, s2;
    do_set(5'd24, 6'd60, 6'd63, 1'b0, s0, s1, s2);
    vectors++;
    if ({hh, mm, ss} !== {5'd23, 6'd59, 6'd59}) begin
      miscompares++;
      $display("FAIL clamp: got %0d:%0d:%0d expected 23:59:59", hh, mm, ss);
    end
  endtask

  task automatic test_reset_mid_sequence;
    logic [20:0] seq [4];
    seq = '{W_PL, W_PH, W_ST, W_CT};
    @(posedge clk); #1;
    set_time = 1'b1; set_hh = 5'd1; set_mm = 6'd2; set_ss = 6'd3;
    @(posedge clk); #1; set_time = 1'b0;   // RS_PL
    @(posedge clk); #1;                    // CLR
    @(posedge clk); #1; reset = 1'b1;      // CTRL
    @(negedge clk);
    vectors++;
    if ({tmr_chipselect, tmr_write_n} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_ctrl_abandon: got cs=%b wn=%b expected 0 1",
               tmr_chipselect, tmr_write_n);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus !== seq[i]) begin
        miscompares++;
        $display("FAIL rst_restart_write%0d: got %h expected %h",
                 i, bus, seq[i]);
      end
      if (i == 0) begin
        vectors++;
        if ({hh, mm, ss, tick_1hz, alarm_active, running} !== 20'd0) begin
          miscompares++;
          $display("FAIL rst_outputs: got %0d:%0d:%0d tk=%b al=%b run=%b",
                   hh, mm, ss, tick_1hz, alarm_active, running);
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({tmr_chipselect, running} !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_rerun: got cs=%b run=%b expected 0 1",
               tmr_chipselect, running);
    end
  endtask

  initial begin
    reset = 1'b1; tmr_irq = 1'b0; set_time = 1'b0;
    set_hh = 5'd0; set_mm = 6'd0; set_ss = 6'd0;
    alarm_hh = 5'd0; alarm_mm = 6'd0; alarm_en = 1'b0; alarm_ack = 1'b0;
    test_reset;
    test_tick;
    test_rollover;
    test_alarm;
    test_set_irq_collision;
    test_clamp;
    test_reset_mid_sequence;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
